// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: RAM, screen shadow with framebuffer write queue, keyboard latch.
// Optional HACK_KBD_ACK_EN: a CPU write to KBD_ADDR clears the keyboard register.
module hack_data_mem #(
  parameter int          RAM_AW     = 14,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [14:0] KBD_ADDR   = 15'h6000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_overflow,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [15:0] ram    [0:(2**RAM_AW)-1];
  logic [15:0] shadow [0:8191];
  logic [28:0] queue  [0:FIFO_DEPTH-1];

  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0]   count;
  logic [15:0]   kbdReg;

  logic isRam, isScreen, isKbd;
  logic pushReq, pop, full, doPush;

  assign isRam    = ~addressM[14];
  assign isScreen = (addressM[14:13] == 2'b10);
  assign isKbd    = (addressM == KBD_ADDR);

  assign full     = (count == DEPTH_C);
  assign fb_valid = (count != '0);
  assign pushReq  = writeM & isScreen;
  assign pop      = fb_valid & fb_ready;
  // A push into a full queue still lands when the head leaves in the same cycle.
  assign doPush   = pushReq & (~full | pop);

  assign fb_addr = queue[rdPtr][28:16];
  assign fb_data = queue[rdPtr][15:0];

  always_comb begin
    inM = 16'h0000;
    if (isRam)
      inM = ram[addressM[RAM_AW-1:0]];
    else if (isScreen)
      inM = shadow[addressM[12:0]];
    else if (isKbd)
      inM = kbdReg;
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (writeM & isRam)
      ram[addressM[RAM_AW-1:0]] <= outM;
    if (pushReq)
      shadow[addressM[12:0]] <= outM;
    if (doPush)
      queue[wrPtr] <= {addressM[12:0], outM};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      fb_overflow <= 1'b0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      case ({doPush, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pushReq & ~doPush)
        fb_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      kbdReg <= 16'h0000;
    else if (kbd_valid)
      kbdReg <= kbd_code;
`ifdef HACK_KBD_ACK_EN
    else if (writeM & isKbd)
      kbdReg <= 16'h0000;
`else
    else
      kbdReg <= kbdReg;
`endif
  end

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: memory decode, screen queue handshake/overflow, keyboard, async reset.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        fb_valid;
  logic        fb_ready;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_overflow;
  logic        kbd_valid;
  logic [15:0] kbd_code;

  int nChecks = 0;
  int nFail   = 0;

  hack_data_mem dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_overflow(fb_overflow),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpuWrite(input logic [14:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
  endtask

  task automatic readAt(input logic [14:0] a);
    addressM = a;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    addressM  = 15'h0000;
    outM      = 16'h0000;
    writeM    = 1'b0;
    fb_ready  = 1'b0;
    kbd_valid = 1'b0;
    kbd_code  = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_fb_valid", 16'(fb_valid), 16'h0);
    check("rst_overflow", 16'(fb_overflow), 16'h0);
    readAt(15'h6000);
    check("rst_kbd", inM, 16'h0000);
    reset_n = 1'b1;
    tick();

    // RAM write/read, boundaries, unmapped
    cpuWrite(15'h0010, 16'h1234);
    check("ram_rdw_0010", inM, 16'h1234);
    cpuWrite(15'h3FFF, 16'hBEEF);
    check("ram_top_3fff", inM, 16'hBEEF);
    readAt(15'h7000);
    check("unmapped_7000", inM, 16'h0000);
    cpuWrite(15'h6001, 16'h5555);
    check("unmapped_6001", inM, 16'h0000);
    check("unmapped_no_push", 16'(fb_valid), 16'h0);

    // Single screen write with ready high
    fb_ready = 1'b1;
    cpuWrite(15'h4005, 16'hFFFF);
    check("scr_valid", 16'(fb_valid), 16'h1);
    check("scr_addr", 16'(fb_addr), 16'h0005);
    check("scr_data", fb_data, 16'hFFFF);
    tick();
    check("scr_popped", 16'(fb_valid), 16'h0);
    readAt(15'h4005);
    check("scr_shadow", inM, 16'hFFFF);
    cpuWrite(15'h5FFF, 16'h0F0F);
    check("scr_top_5fff", inM, 16'h0F0F);
    tick();

    // Fill past capacity with ready low
    fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpuWrite(15'h4000 + 15'(i), 16'hA000 + 16'(i));
      if (i == 7) check("ovf_not_yet", 16'(fb_overflow), 16'h0);
    end
    check("ovf_set", 16'(fb_overflow), 16'h1);
    check("ovf_head_hold", fb_data, 16'hA000);
    tick();
    check("ovf_head_stable", fb_data, 16'hA000);
    readAt(15'h4008);
    check("ovf_shadow_9th", inM, 16'hA008);
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 16'(fb_valid), 16'h1);
      check("drain_addr", 16'(fb_addr), 16'(i));
      check("drain_data", fb_data, 16'hA000 + 16'(i));
      tick();
    end
    check("drain_empty", 16'(fb_valid), 16'h0);
    check("ovf_sticky", 16'(fb_overflow), 16'h1);
    fb_ready = 1'b0;

    // Keyboard latch and CPU write to the keyboard address
    kbd_code  = 16'h0083;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    readAt(15'h6000);
    check("kbd_latch", inM, 16'h0083);
    cpuWrite(15'h6000, 16'h0000);
`ifdef HACK_KBD_ACK_EN
    check("kbd_ack", inM, 16'h0000);
`else
    check("kbd_ack", inM, 16'h0083);
`endif
    kbd_code  = 16'h0041;
    kbd_valid = 1'b1;
    cpuWrite(15'h6000, 16'h0000);
    kbd_valid = 1'b0;
    check("kbd_wins", inM, 16'h0041);
    kbd_code  = 16'h0000;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    check("kbd_release", inM, 16'h0000);
    kbd_code  = 16'h0055;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;

    // Asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++)
      cpuWrite(15'h4100 + 15'(i), 16'hC000 + 16'(i));
    check("pre_rst_valid", 16'(fb_valid), 16'h1);
    readAt(15'h6000);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 16'(fb_valid), 16'h0);
    check("arst_overflow", 16'(fb_overflow), 16'h0);
    check("arst_kbd", inM, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    readAt(15'h0010);
    check("arst_ram_kept", inM, 16'h1234);
    check("arst_still_empty", 16'(fb_valid), 16'h0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++)
      cpuWrite(15'h4200 + 15'(i), 16'hB000 + 16'(i));
    check("full_no_ovf", 16'(fb_overflow), 16'h0);
    fb_ready = 1'b1;
    cpuWrite(15'h4208, 16'hB008);
    fb_ready = 1'b0;
    check("full_pp_no_ovf", 16'(fb_overflow), 16'h0);
    check("full_pp_head", fb_data, 16'hB001);
    fb_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check("full_pp_valid", 16'(fb_valid), 16'h1);
      check("full_pp_data", fb_data, 16'hB000 + 16'(i));
      tick();
    end
    check("full_pp_empty", 16'(fb_valid), 16'h0);

    // Push and pop together with a single entry queued
    cpuWrite(15'h4300, 16'hD000);
    check("one_valid", 16'(fb_valid), 16'h1);
    cpuWrite(15'h4301, 16'hD001);
    check("one_pp_valid", 16'(fb_valid), 16'h1);
    check("one_pp_data", fb_data, 16'hD001);
    check("one_pp_addr", 16'(fb_addr), 16'h0301);
    tick();
    check("one_pp_empty", 16'(fb_valid), 16'h0);
    check("end_no_ovf", 16'(fb_overflow), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
